// File: rtl/game_pkg.sv
// Shared encodings for the flappy-bird game blocks: play-state codes and helpers.
package game_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] READY = 3'd1;
    localparam logic [STATE_W-1:0] PLAY  = 3'd2;
    localparam logic [STATE_W-1:0] DYING = 3'd3;
    localparam logic [STATE_W-1:0] OVER  = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Control/status bundle between the game sequencer and the surrounding game logic.
interface game_ctrl_if #(
    parameter int SCORE_W = 10
);
    import game_pkg::*;

    logic                 frame_en;
    logic                 btn;
    logic                 collision;
    logic                 score_pulse;
    logic                 game_active;
    logic                 freeze;
    logic                 flap_pulse;
    logic [STATE_W-1:0]   state;
    logic [1:0]           countdown;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   best;
    logic                 new_best;

    modport master (
        output frame_en, btn, collision, score_pulse,
        input  game_active, freeze, flap_pulse, state, countdown, score, best, new_best
    );

    modport slave (
        input  frame_en, btn, collision, score_pulse,
        output game_active, freeze, flap_pulse, state, countdown, score, best, new_best
    );

endinterface

// File: rtl/game_ctrl_edge_rise.sv
// Registered rising-edge detector: remembers last sample, flags a 0->1 change.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// Flappy-bird play sequencer: IDLE/READY/PLAY/DYING/OVER, score and session best,
// and the single-cycle flap strobe for the bird physics.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SEC_FRAMES   = 60,
    parameter int READY_SECS   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int LOCK_FRAMES  = 30,
    parameter int SCORE_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    game_ctrl_if.slave  bus
);

    localparam int READY_LEN = READY_SECS * SEC_FRAMES;
    localparam int FC_MAX    = max3(READY_LEN, DEATH_FRAMES, LOCK_FRAMES);
    localparam int FC_W      = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

    localparam logic [FC_W-1:0] READY_LOAD = FC_W'(READY_LEN - 1);
    localparam logic [FC_W-1:0] DEATH_LOAD = FC_W'(DEATH_FRAMES - 1);
    localparam logic [FC_W-1:0] LOCK_LOAD  = FC_W'(LOCK_FRAMES - 1);
    localparam logic [FC_W-1:0] CNT_ONE    = FC_W'(1);

    // Score saturates at all-ones instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [1:0] secs_left(input logic [FC_W-1:0] c);
        return 2'(32'(c) / 32'(SEC_FRAMES) + 32'd1);
    endfunction

    logic btn_rise;
    logic sp_rise;

    edge_rise u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn),
        .rise  (btn_rise)
    );

    edge_rise u_sp_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.score_pulse),
        .rise  (sp_rise)
    );

    logic [STATE_W-1:0] state_q,    state_d;
    logic [FC_W-1:0]    cnt_q,      cnt_d;
    logic [SCORE_W-1:0] score_q,    score_d;
    logic [SCORE_W-1:0] best_q,     best_d;
    logic               new_best_q, new_best_d;
    logic               active_q;
    logic               freeze_q;
    logic               flap_q,     flap_d;
    logic [1:0]         cd_q,       cd_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        best_d     = best_q;
        new_best_d = new_best_q;

        case (state_q)
            IDLE: begin
                if (btn_rise) begin
                    state_d    = READY;
                    cnt_d      = READY_LOAD;
                    score_d    = '0;
                    new_best_d = 1'b0;
                end
            end

            READY: begin
                if (bus.frame_en) begin
                    if (cnt_q == '0) state_d = PLAY;
                    else             cnt_d   = cnt_q - CNT_ONE;
                end
            end

            PLAY: begin
                // A point scored on the collision frame still counts.
                if (sp_rise) score_d = sat_inc(score_q);
                if (bus.frame_en && bus.collision) begin
                    state_d = DYING;
                    cnt_d   = DEATH_LOAD;
                end
            end

            DYING: begin
                if (bus.frame_en) begin
                    if (cnt_q == '0) begin
                        state_d = OVER;
                        cnt_d   = LOCK_LOAD;
                        if (score_q > best_q) begin
                            best_d     = score_q;
                            new_best_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            OVER: begin
                // Button is locked out until the counter has drained to zero.
                if (btn_rise && cnt_q == '0) begin
                    state_d    = READY;
                    cnt_d      = READY_LOAD;
                    score_d    = '0;
                    new_best_d = 1'b0;
                end else if (bus.frame_en && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        flap_d = (state_q == PLAY) && btn_rise;
        cd_d   = (state_d == READY) ? secs_left(cnt_d) : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            score_q    <= '0;
            best_q     <= '0;
            new_best_q <= 1'b0;
            active_q   <= 1'b0;
            freeze_q   <= 1'b0;
            flap_q     <= 1'b0;
            cd_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            active_q   <= (state_d == PLAY);
            freeze_q   <= (state_d == DYING);
            flap_q     <= flap_d;
            cd_q       <= cd_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.countdown   = cd_q;
    assign bus.score       = score_q;
    assign bus.best        = best_q;
    assign bus.new_best    = new_best_q;
    assign bus.game_active = active_q;
    assign bus.freeze      = freeze_q;
    assign bus.flap_pulse  = flap_q;

endmodule
